// File: rtl/exercise_max_pkg.sv
// Shared constants, FSM encoding and the pipeline payload for the exercise_max stage.
package exercise_max_pkg;
  localparam int RD_LAT = 3;
  localparam int W      = 64;
  localparam int AW     = 13;
  localparam int LANES  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  typedef struct packed {
    logic [LANES-1:0][W-1:0] cont;
    logic [LANES-1:0]        mask;
    logic                    last;
  } grp_t;
endpackage

// File: rtl/exercise_max_if.sv
// Continuation / vex / result bus of the exercise_max stage.
interface exercise_max_if;
  import exercise_max_pkg::*;

  logic                 start;
  logic [AW-1:0]        n_steps;
  logic                 cont_valid;
  logic                 cont_ready;
  logic [W-1:0]         cont0, cont1, cont2, cont3;
  logic [AW-1:0]        vexaddr;
  logic [W-1:0]         chan0, chan1, chan2, chan3;
  logic                 out_valid;
  logic [W-1:0]         out0, out1, out2, out3;
  logic [LANES-1:0]     out_mask;
  logic [LANES-1:0]     out_exer;
  logic                 out_last;
  logic                 done;

  modport master (
    output start, n_steps, cont_valid, cont0, cont1, cont2, cont3,
           chan0, chan1, chan2, chan3,
    input  cont_ready, vexaddr, out_valid, out0, out1, out2, out3,
           out_mask, out_exer, out_last, done
  );

  modport slave (
    input  start, n_steps, cont_valid, cont0, cont1, cont2, cont3,
           chan0, chan1, chan2, chan3,
    output cont_ready, vexaddr, out_valid, out0, out1, out2, out3,
           out_mask, out_exer, out_last, done
  );
endinterface

// File: rtl/exercise_max_dbl_max.sv
// Combinational max of two non-NaN doubles; exer_o set only when vex is strictly larger.
module dbl_max import exercise_max_pkg::*; (
  input  logic [W-1:0] cont_i,
  input  logic [W-1:0] vex_i,
  output logic [W-1:0] max_o,
  output logic         exer_o
);
  logic         sc, sv;
  logic [W-2:0] mc, mv;

  assign sc = cont_i[W-1];
  assign sv = vex_i[W-1];
  assign mc = cont_i[W-2:0];
  assign mv = vex_i[W-2:0];

  // +0 and -0 compare equal, so both-zero falls back to continuation
  always_comb begin
    if (mc == '0 && mv == '0) exer_o = 1'b0;
    else if (sc != sv)        exer_o = sc;
    else if (!sc)             exer_o = mv > mc;
    else                      exer_o = mv < mc;
  end

  assign max_o = exer_o ? vex_i : cont_i;
endmodule

// File: rtl/exercise_max.sv
// Backward-induction row walker: addresses vex, delays continuations, emits per-lane max.
module exercise_max import exercise_max_pkg::*; (
  input  logic           clk_fast,
  input  logic           nrst,
  exercise_max_if.slave  bus
);
  state_e                  state_q, state_d;
  logic [AW-1:0]           row_q, row_d, j_q, j_d, n_q, n_d, vexaddr_q, vexaddr_d;
  logic                    acc, grp_last;
  logic [LANES-1:0][W-1:0] cont_v, chan_v, cont_s, max_v, res_v, out_q;
  logic [LANES-1:0]        gt_v, out_mask_q, out_exer_q;
  logic                    out_valid_q, out_last_q;
  logic [RD_LAT:1]         vld_pipe_q;
  grp_t                    grp_in, grp_s;
  grp_t                    grp_q [1:RD_LAT];

  assign cont_v = {bus.cont3, bus.cont2, bus.cont1, bus.cont0};
  assign chan_v = {bus.chan3, bus.chan2, bus.chan1, bus.chan0};
  assign acc    = bus.cont_valid && (state_q == RUN);

  assign grp_last = ({1'b0, j_q} + (AW+1)'(LANES)) > {1'b0, row_q};

  always_comb begin
    grp_in.cont = cont_v;
    grp_in.last = grp_last;
    for (int k = 0; k < LANES; k++) grp_in.mask[k] = (j_q + AW'(k)) <= row_q;
  end

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    j_d       = j_q;
    n_d       = n_q;
    vexaddr_d = vexaddr_q;
    case (state_q)
      IDLE: if (bus.start) begin
        if (bus.n_steps != '0) begin
          state_d = RUN;
          n_d     = bus.n_steps;
          row_d   = bus.n_steps - AW'(1);
          j_d     = '0;
        end else begin
          state_d = DONE;
        end
      end
      RUN: if (acc) begin
        vexaddr_d = (n_q - row_q) + {j_q[AW-2:0], 1'b0};
        if (grp_last) begin
          j_d   = '0;
          row_d = row_q - AW'(1);
          if (row_q == '0) state_d = DRAIN;
        end else begin
          j_d = j_q + AW'(LANES);
        end
      end
      DRAIN: if (vld_pipe_q == '0) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign grp_s  = grp_q[RD_LAT];
  assign cont_s = grp_s.cont;

  dbl_max u_max [LANES-1:0] (
    .cont_i (cont_s),
    .vex_i  (chan_v),
    .max_o  (max_v),
    .exer_o (gt_v)
  );

  always_comb begin
    for (int k = 0; k < LANES; k++) res_v[k] = grp_s.mask[k] ? max_v[k] : '0;
  end

  always_ff @(posedge clk_fast) begin
    if (!nrst) begin
      state_q     <= IDLE;
      row_q       <= '0;
      j_q         <= '0;
      n_q         <= '0;
      vexaddr_q   <= '0;
      vld_pipe_q  <= '0;
      for (int s = 1; s <= RD_LAT; s++) grp_q[s] <= '0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      out_mask_q  <= '0;
      out_exer_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      row_q         <= row_d;
      j_q           <= j_d;
      n_q           <= n_d;
      vexaddr_q     <= vexaddr_d;
      vld_pipe_q[1] <= acc;
      grp_q[1]      <= grp_in;
      for (int s = 2; s <= RD_LAT; s++) begin
        vld_pipe_q[s] <= vld_pipe_q[s-1];
        grp_q[s]      <= grp_q[s-1];
      end
      // chan0..3 line up with the last delay stage
      out_valid_q <= vld_pipe_q[RD_LAT];
      out_q       <= vld_pipe_q[RD_LAT] ? res_v : '0;
      out_mask_q  <= vld_pipe_q[RD_LAT] ? grp_s.mask : '0;
      out_exer_q  <= vld_pipe_q[RD_LAT] ? (gt_v & grp_s.mask) : '0;
      out_last_q  <= vld_pipe_q[RD_LAT] && grp_s.last;
    end
  end

  assign bus.cont_ready = (state_q == RUN);
  assign bus.done       = (state_q == DONE);
  assign bus.vexaddr    = vexaddr_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out0       = out_q[0];
  assign bus.out1       = out_q[1];
  assign bus.out2       = out_q[2];
  assign bus.out3       = out_q[3];
  assign bus.out_mask   = out_mask_q;
  assign bus.out_exer   = out_exer_q;
  assign bus.out_last   = out_last_q;
endmodule
